wb_arbiter2: RTL

WB_ARBITER2 -- requirements
Module: wb_arbiter2

---
 rtl/wb_arbiter2.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/wb_arbiter2.sv
// -----------------------------------------------------------------------------
// wb_arbiter2 -- two-master Wishbone arbiter with a stall watchdog.
//
// Grants one of two Wishbone masters (m0 = core, m1 = second master) access
// to a single slave-side port, which feeds the address decoder. A tenure is
// locked for as long as the granted master holds CYC. When both masters
// request at once, the master that was not served last wins.
//
// A watchdog counts stalled strobe cycles (STB high with no ACK/ERR/RTY).
// When it reaches TIMEOUT, the access is terminated with ERR toward the
// master and a one-cycle 'timeout' pulse.
//
// Parameters
//   TIMEOUT      number of stall cycles before the watchdog fires (>= 1)
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   m0_* / m1_*  master ports: CYC, STB, WE, ADR, DAT_O, CTI_O in;
//                ACK, ERR, RTY, DAT_I out
//   s_*          slave port: CYC, STB, WE, ADR, DAT_O, CTI_O out;
//                ACK, ERR, RTY, DAT_I in
//   gnt          registered one-hot grant (bit0 = m0, bit1 = m1), 00 = idle
//   timeout      single-cycle pulse when the watchdog fires
// -----------------------------------------------------------------------------
module wb_arbiter2 #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_CYC,
    input  logic        m0_STB,
    input  logic        m0_WE,
    input  logic [31:0] m0_ADR,
    input  logic [31:0] m0_DAT_O,
    input  logic [2:0]  m0_CTI_O,
    output logic        m0_ACK,
    output logic        m0_ERR,
    output logic        m0_RTY,
    output logic [31:0] m0_DAT_I,

    input  logic        m1_CYC,
    input  logic        m1_STB,
    input  logic        m1_WE,
    input  logic [31:0] m1_ADR,
    input  logic [31:0] m1_DAT_O,
    input  logic [2:0]  m1_CTI_O,
    output logic        m1_ACK,
    output logic        m1_ERR,
    output logic        m1_RTY,
    output logic [31:0] m1_DAT_I,

    output logic        s_CYC,
    output logic        s_STB,
    output logic        s_WE,
    output logic [31:0] s_ADR,
    output logic [31:0] s_DAT_O,
    output logic [2:0]  s_CTI_O,
    input  logic        s_ACK,
    input  logic        s_ERR,
    input  logic        s_RTY,
    input  logic [31:0] s_DAT_I,

    output logic [1:0]  gnt,
    output logic        timeout
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TIMEOUT_VAL = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS0 = 2'd1,
        ST_BUS1 = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      gnt_q, gnt_d;
    logic            last_q, last_d;     // master served last (0 = m0, 1 = m1)
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            mst_cyc;            // CYC of the granted master
    logic            mst_stb;            // STB of the granted master
    logic            s_resp;
    logic            wd_fire;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= 2'b00;
            last_q  <= 1'b1;             // m0 wins the first contention
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            ST_IDLE: begin
                if (m0_CYC && m1_CYC) begin
                    state_d = last_q ? ST_BUS0 : ST_BUS1;
                end else if (m0_CYC) begin
                    state_d = ST_BUS0;
                end else if (m1_CYC) begin
                    state_d = ST_BUS1;
                end
            end
            ST_BUS0: begin
                // Tenure is locked: m1 is only looked at once m0 lets go.
                if (!m0_CYC) begin
                    last_d  = 1'b0;
                    state_d = m1_CYC ? ST_BUS1 : ST_IDLE;
                end
            end
            ST_BUS1: begin
                if (!m1_CYC) begin
                    last_d  = 1'b1;
                    state_d = m0_CYC ? ST_BUS0 : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // gnt is registered alongside the state so it is glitch-free.
        unique case (state_d)
            ST_BUS0: gnt_d = 2'b01;
            ST_BUS1: gnt_d = 2'b10;
            default: gnt_d = 2'b00;
        endcase
    end

    // -------------------------------------------------------------------------
    // Watchdog
    // -------------------------------------------------------------------------
    always_comb begin
        mst_cyc = 1'b0;
        mst_stb = 1'b0;
        if (state_q == ST_BUS0) begin
            mst_cyc = m0_CYC;
            mst_stb = m0_STB;
        end else if (state_q == ST_BUS1) begin
            mst_cyc = m1_CYC;
            mst_stb = m1_STB;
        end

        s_resp = s_ACK | s_ERR | s_RTY;

        // A genuine slave response in the expiry cycle wins over the watchdog.
        wd_fire = mst_cyc && mst_stb && !s_resp && (cnt_q == TIMEOUT_VAL);

        if (state_q == ST_IDLE || state_d != state_q || !mst_cyc || !mst_stb
            || s_resp || wd_fire) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Output logic
    // -------------------------------------------------------------------------
    always_comb begin
        s_CYC   = 1'b0;
        s_STB   = 1'b0;
        s_WE    = 1'b0;
        s_ADR   = 32'h0;
        s_DAT_O = 32'h0;
        s_CTI_O = 3'b000;
        m0_ACK  = 1'b0;
        m0_ERR  = 1'b0;
        m0_RTY  = 1'b0;
        m1_ACK  = 1'b0;
        m1_ERR  = 1'b0;
        m1_RTY  = 1'b0;
        unique case (state_q)
            ST_BUS0: begin
                s_CYC   = m0_CYC;
                s_STB   = m0_STB & ~wd_fire;   // withdraw the strobe on expiry
                s_WE    = m0_WE;
                s_ADR   = m0_ADR;
                s_DAT_O = m0_DAT_O;
                s_CTI_O = m0_CTI_O;
                m0_ACK  = s_ACK;
                m0_ERR  = s_ERR | wd_fire;
                m0_RTY  = s_RTY;
            end
            ST_BUS1: begin
                s_CYC   = m1_CYC;
                s_STB   = m1_STB & ~wd_fire;
                s_WE    = m1_WE;
                s_ADR   = m1_ADR;
                s_DAT_O = m1_DAT_O;
                s_CTI_O = m1_CTI_O;
                m1_ACK  = s_ACK;
                m1_ERR  = s_ERR | wd_fire;
                m1_RTY  = s_RTY;
            end
            default: ;
        endcase
    end

    // Read data is broadcast; only the granted master sees a qualifying ACK.
    assign m0_DAT_I = s_DAT_I;
    assign m1_DAT_I = s_DAT_I;
    assign gnt      = gnt_q;
    assign timeout  = wd_fire;

endmodule
